// File: rtl/fire_arb_pkg.sv
// Shared types and constants for the bullet-slot fire arbiter.
// Optional build macro FIRE_ARB_PLAYER_PRIORITY_EN is consumed by fire_arbiter.
package fire_arb_pkg;

    localparam int COORD_W          = 10;
    localparam int COOLDOWN_CYC_DEF = 200000;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SPAWN  = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_SPAWN  = SPAWN,
        ST_SETTLE = SETTLE
    } arb_state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } coord_t;

    // Counter must hold COOLDOWN_CYC-1; keep at least one bit when that is 0.
    function automatic int cd_width(input int cyc);
        return (cyc <= 2) ? 1 : $clog2(cyc);
    endfunction

endpackage

// File: rtl/fire_arbiter_rr_pick.sv
// Combinational round-robin picker: searches from ptr_i+1 upward, wrapping,
// and returns the first set request as one-hot and as an index.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int   j;
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/fire_arbiter.sv
// Fire arbiter: grants one requester a free bullet slot per 3-cycle spawn.
// Define FIRE_ARB_PLAYER_PRIORITY_EN to let requester 0 pre-empt round-robin.
module fire_arbiter
    import fire_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int SLOT_COUNT   = 8,
    parameter int SLOT_W       = 3,
    parameter int COOLDOWN_CYC = COOLDOWN_CYC_DEF
) (
    input  logic                       clk25,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*COORD_W-1:0] req_x,
    input  logic [NUM_REQ*COORD_W-1:0] req_y,
    input  logic [SLOT_COUNT-1:0]      slot_busy,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       spawn_valid,
    output logic [SLOT_W-1:0]          spawn_slot,
    output logic [COORD_W-1:0]         spawn_x,
    output logic [COORD_W-1:0]         spawn_y,
    output logic [1:0]                 spawn_owner,
    output logic                       pool_full
);

    localparam int          CD_W    = cd_width(COOLDOWN_CYC);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_CYC - 1);

    arb_state_e                       state_q, state_d;
    logic [1:0]                       owner_q, owner_d;
    logic [NUM_REQ-1:0]               gnt_q, gnt_d;
    logic [SLOT_W-1:0]                slot_q, slot_d;
    coord_t                           pos_q, pos_d;
    logic [1:0]                       ptr_q, ptr_d;
    logic [SLOT_COUNT-1:0]            reserved_q, reserved_d;
    logic                             pool_full_q;
    logic [NUM_REQ-1:0][CD_W-1:0]     cd_q;

    logic [NUM_REQ-1:0] elig, rr_req, rr_gnt, win_oh;
    logic [1:0]         rr_idx, win_idx;
    logic               rr_any, win_any;
    logic [SLOT_W-1:0]  free_idx;
    logic               free_found;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = req[i] && (cd_q[i] == '0);
    end

`ifdef FIRE_ARB_PLAYER_PRIORITY_EN
    // Player bypasses the rotation; the others rotate among themselves.
    assign rr_req  = elig & ~NUM_REQ'(1);
    assign win_any = elig[0] | rr_any;
    assign win_idx = elig[0] ? 2'd0 : rr_idx;
    assign win_oh  = elig[0] ? NUM_REQ'(1) : rr_gnt;
`else
    assign rr_req  = elig;
    assign win_any = rr_any;
    assign win_idx = rr_idx;
    assign win_oh  = rr_gnt;
`endif

    rr_pick #(.N(NUM_REQ), .IDX_W(2)) u_rr (
        .req_i (rr_req),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt),
        .idx_o (rr_idx),
        .any_o (rr_any)
    );

    // Lowest free slot: neither busy in the datapath nor reserved by us.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
            if (!slot_busy[i] && !reserved_q[i]) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        gnt_d      = gnt_q;
        slot_d     = slot_q;
        pos_d      = pos_q;
        ptr_d      = ptr_q;
        reserved_d = reserved_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_any && free_found) begin
                    state_d              = ST_SPAWN;
                    owner_d              = win_idx;
                    gnt_d                = win_oh;
                    slot_d               = free_idx;
                    pos_d.x              = req_x[int'(win_idx)*COORD_W +: COORD_W];
                    pos_d.y              = req_y[int'(win_idx)*COORD_W +: COORD_W];
                    reserved_d[free_idx] = 1'b1;
                end
            end
            ST_SPAWN: begin
                state_d = ST_SETTLE;
`ifdef FIRE_ARB_PLAYER_PRIORITY_EN
                if (owner_q != 2'd0)
                    ptr_d = owner_q;
`else
                ptr_d = owner_q;
`endif
            end
            ST_SETTLE: begin
                // Datapath has raised slot_busy by now, so the hold can go.
                reserved_d[slot_q] = 1'b0;
                state_d            = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            gnt_q       <= '0;
            slot_q      <= '0;
            pos_q       <= '0;
            ptr_q       <= 2'(NUM_REQ - 1);
            reserved_q  <= '0;
            pool_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            slot_q      <= slot_d;
            pos_q       <= pos_d;
            ptr_q       <= ptr_d;
            reserved_q  <= reserved_d;
            pool_full_q <= &(slot_busy | reserved_q);
        end
    end

    // Cooldowns run regardless of FSM state; a grant reloads the winner's.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            cd_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (state_q == ST_SPAWN && gnt_q[i])
                    cd_q[i] <= CD_LOAD;
                else if (cd_q[i] != '0)
                    cd_q[i] <= cd_q[i] - 1'b1;
            end
        end
    end

    assign spawn_valid = (state_q == ST_SPAWN);
    assign grant       = spawn_valid ? gnt_q : '0;
    assign spawn_slot  = slot_q;
    assign spawn_x     = pos_q.x;
    assign spawn_y     = pos_q.y;
    assign spawn_owner = owner_q;
    assign pool_full   = pool_full_q;

endmodule
